// File: rtl/sm_pkg.sv
// Shared definitions for the sm_in_cond input conditioner: channel state
// encoding, default parameter values and the debounce counter width helper.
package sm_pkg;

  localparam logic [0:0] DB_STABLE = 1'b0;
  localparam logic [0:0] DB_CHECK  = 1'b1;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;
  localparam int GC_W_DEF        = 8;

  // Bits needed to hold db_cycles-1 (never less than one bit).
  function automatic int cnt_width(input int db_cycles);
    return (db_cycles > 2) ? $clog2(db_cycles) : 1;
  endfunction

endpackage

// File: rtl/sm_in_debounce.sv
// One conditioner channel: SYNC_STAGES-deep synchroniser followed by a
// STABLE/CHECK debounce FSM; the FSM exists only when SM_IN_DEBOUNCE_EN is defined.
module sm_in_debounce
  import sm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic rej
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_param_check
    $error("sm_in_debounce: SYNC_STAGES or DB_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_ff[SYNC_STAGES-1];

`ifdef SM_IN_DEBOUNCE_EN
  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  // A bounce back to the accepted level while checking is a rejected glitch.
  always_comb begin
    rej = (state == DB_CHECK) && (s == q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DB_STABLE;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      case (state)
        DB_STABLE: begin
          if (s != q) begin
            state <= DB_CHECK;
            cnt   <= CW'(1);
          end
        end
        DB_CHECK: begin
          if (s == q) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            q     <= s;
            state <= DB_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= DB_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign q   = s;
  assign rej = 1'b0;
`endif

endmodule

// File: rtl/sm_in_cond.sv
// Two-channel input conditioner feeding the FSM i1/i2 inputs: change pulse and
// saturating glitch counter. Debounce is built only with SM_IN_DEBOUNCE_EN defined.
module sm_in_cond
  import sm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int GC_W        = GC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i1_raw,
  input  logic            i2_raw,
  output logic            i1,
  output logic            i2,
  output logic            chg,
  output logic [GC_W-1:0] glitch_cnt
);

  localparam int SW = GC_W + 1;
  localparam logic [SW-1:0] GC_MAX = {1'b0, {GC_W{1'b1}}};

  logic          rej1;
  logic          rej2;
  logic          i1_prev;
  logic          i2_prev;
  logic [SW-1:0] gc_sum;

  sm_in_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_ch1 (
    .clk (clk),
    .rst (rst),
    .raw (i1_raw),
    .q   (i1),
    .rej (rej1)
  );

  sm_in_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_ch2 (
    .clk (clk),
    .rst (rst),
    .raw (i2_raw),
    .q   (i2),
    .rej (rej2)
  );

  // Simultaneous changes on both channels collapse into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_prev <= 1'b0;
      i2_prev <= 1'b0;
      chg     <= 1'b0;
    end else begin
      i1_prev <= i1;
      i2_prev <= i2;
      chg     <= (i1 != i1_prev) || (i2 != i2_prev);
    end
  end

  // One spare bit so a +2 step near the top is seen and clamped, never wrapped.
  always_comb begin
    gc_sum = {1'b0, glitch_cnt} + SW'(rej1) + SW'(rej2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (gc_sum > GC_MAX) begin
      glitch_cnt <= {GC_W{1'b1}};
    end else begin
      glitch_cnt <= gc_sum[GC_W-1:0];
    end
  end

endmodule

// File: tb/tb_sm_in_cond.sv
// Bench for sm_in_cond: directed scenarios plus random raw levels, checked every
// cycle against a run-length reference model; follows SM_IN_DEBOUNCE_EN like the RTL.
module tb_sm_in_cond;

  localparam int SYNC = 2;
  localparam int DB   = 4;
`ifdef SM_IN_DEBOUNCE_EN
  localparam bit EN      = 1'b1;
  localparam int EXP_LAT = SYNC + DB;
`else
  localparam bit EN      = 1'b0;
  localparam int EXP_LAT = SYNC;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i1_raw;
  logic       i2_raw;
  logic       i1, i2, chg;
  logic [7:0] glitch_cnt;
  logic       i1_b, i2_b, chg_b;
  logic [1:0] glitch_cnt_b;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  sm_in_cond #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GC_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i1_raw     (i1_raw),
    .i2_raw     (i2_raw),
    .i1         (i1),
    .i2         (i2),
    .chg        (chg),
    .glitch_cnt (glitch_cnt)
  );

  sm_in_cond #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GC_W(2)) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .i1_raw     (i1_raw),
    .i2_raw     (i2_raw),
    .i1         (i1_b),
    .i2         (i2_b),
    .chg        (chg_b),
    .glitch_cnt (glitch_cnt_b)
  );

  // Reference model: raw history per channel, run length of disagreement.
  bit sh1[$];
  bit sh2[$];
  bit m_q[2];
  int m_run[2];
  int m_glitch;
  bit m_chg;
  bit m_changed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sh1 = {};
    sh2 = {};
    for (int i = 0; i < SYNC; i++) begin
      sh1.push_back(1'b0);
      sh2.push_back(1'b0);
    end
    m_q[0] = 1'b0; m_q[1] = 1'b0;
    m_run[0] = 0; m_run[1] = 0;
    m_glitch = 0;
    m_chg = 1'b0;
    m_changed = 1'b0;
  endtask

  task automatic model_edge();
    bit s_old[2];
    bit s_new[2];
    bit changed;
    changed = 1'b0;
    s_old[0] = sh1[0];
    s_old[1] = sh2[0];
    m_chg = m_changed;
    sh1.push_back(i1_raw); void'(sh1.pop_front());
    sh2.push_back(i2_raw); void'(sh2.pop_front());
    s_new[0] = sh1[0];
    s_new[1] = sh2[0];
    for (int c = 0; c < 2; c++) begin
      if (EN) begin
        // A new level is accepted after DB consecutive disagreeing samples.
        if (s_old[c] != m_q[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_q[c] = s_old[c];
            m_run[c] = 0;
            changed = 1'b1;
          end
        end else begin
          if (m_run[c] > 0) m_glitch++;
          m_run[c] = 0;
        end
      end else begin
        if (s_new[c] != m_q[c]) changed = 1'b1;
        m_q[c] = s_new[c];
      end
    end
    m_changed = changed;
  endtask

  task automatic compare_all();
    int g8, g2;
    g8 = (m_glitch > 255) ? 255 : m_glitch;
    g2 = (m_glitch > 3) ? 3 : m_glitch;
    check("i1", i1, m_q[0]);
    check("i2", i2, m_q[1]);
    check("chg", chg, m_chg);
    check("glitch_cnt", glitch_cnt, g8);
    check("i1_sat_inst", i1_b, m_q[0]);
    check("i2_sat_inst", i2_b, m_q[1]);
    check("chg_sat_inst", chg_b, m_chg);
    check("glitch_cnt_sat", glitch_cnt_b, g2);
  endtask

  task automatic drive_cycle(input logic a, input logic b);
    i1_raw = a;
    i2_raw = b;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  // Counts edges until i1 changes, bounded by a cycle budget.
  task automatic measure_edge(input logic a, input logic b, input string tag);
    int   n;
    bit   seen;
    logic start;
    n = 0;
    seen = 1'b0;
    start = i1;
    while (!seen && n < 20) begin
      drive_cycle(a, b);
      n++;
      if (i1 != start) seen = 1'b1;
    end
    check(tag, n, EXP_LAT);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    drive_cycle(i1_raw, i2_raw);
    rst = 1'b0;
  endtask

  task automatic settle(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) drive_cycle(a, b);
  endtask

  initial begin
    int g0;
    bit seen_i2;
    int sat_tab[5];
    bit r1, r2;
    int h1, h2;
    sat_tab = '{1, 2, 3, 3, 3};

    // Reset held two cycles with both raw inputs high.
    rst = 1'b1;
    i1_raw = 1'b1;
    i2_raw = 1'b1;
    model_reset();
    #1;
    compare_all();
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    rst = 1'b0;
    measure_edge(1'b1, 1'b1, "rst_release_latency");
    check("rst_release_i2", i2, 1);
    drive_cycle(1'b1, 1'b1);
    check("rst_release_chg", chg, 1);
    drive_cycle(1'b1, 1'b1);
    check("chg_one_cycle", chg, 0);

    // Both channels fall together.
    measure_edge(1'b0, 1'b0, "simul_latency");
    check("simul_i2", i2, 0);
    settle(1'b0, 1'b0, 4);

    // Clean step on channel 1.
    g0 = m_glitch;
    measure_edge(1'b1, 1'b0, "step_latency");
    settle(1'b1, 1'b0, 4);
    check("step_gc", glitch_cnt, g0);

    // Short pulse on channel 2.
    g0 = m_glitch;
    seen_i2 = 1'b0;
    drive_cycle(1'b1, 1'b1);
    if (i2) seen_i2 = 1'b1;
    drive_cycle(1'b1, 1'b1);
    if (i2) seen_i2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0);
      if (i2) seen_i2 = 1'b1;
    end
    check("glitch_i2_seen", seen_i2, EN ? 0 : 1);
    check("glitch_delta1", glitch_cnt, g0 + (EN ? 1 : 0));

    // Both channels glitch in the same cycle.
    g0 = m_glitch;
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1);
    settle(1'b1, 1'b0, 8);
    check("glitch_delta2", glitch_cnt, g0 + (EN ? 2 : 0));

    // Saturation on the narrow counter.
    i1_raw = 1'b0;
    i2_raw = 1'b0;
    pulse_reset();
    settle(1'b0, 1'b0, 2);
    for (int n = 0; n < 5; n++) begin
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      settle(1'b0, 1'b0, 6);
      check("sat_seq", glitch_cnt_b, EN ? sat_tab[n] : 0);
    end

    // Reset in the middle of a debounce.
    settle(1'b1, 1'b0, 4);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_i1", i1, 0);
    check("midrst_gc", glitch_cnt, 0);
    check("midrst_chg", chg, 0);
    compare_all();
    drive_cycle(1'b1, 1'b0);
    rst = 1'b0;
    measure_edge(1'b1, 1'b0, "midrst_latency");

    // Random raw levels with random hold times and occasional resets.
    r1 = 1'b1;
    r2 = 1'b0;
    h1 = 1;
    h2 = 1;
    for (int t = 0; t < 800; t++) begin
      if (--h1 == 0) begin r1 = ~r1; h1 = $urandom_range(1, 8); end
      if (--h2 == 0) begin r2 = ~r2; h2 = $urandom_range(1, 8); end
      if (t == 300 || t == 610) begin
        i1_raw = r1;
        i2_raw = r2;
        pulse_reset();
      end else begin
        drive_cycle(r1, r2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm_in_cond.md
# sm_in_cond

Input conditioner that sits directly upstream of the two-input FSM stage and drives its `i1`/`i2` inputs. It takes two raw, asynchronous control levels, synchronises each into the `clk` domain, and debounces each one. Only a level held stable for a programmable number of cycles reaches the FSM. It also flags every accepted output change and counts rejected glitches for the bench and for debug.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel; legal range 2..4.
- `DB_CYCLES`, default 4: consecutive cycles a new synchronised level must persist before it is accepted; legal range 2..255.
- `GC_W`, default 8: glitch counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i1_raw` input 1: raw control level, channel 1; asynchronous to `clk`.
- `i2_raw` input 1: raw control level, channel 2; asynchronous to `clk`.
- `i1` output 1: conditioned channel 1; connects to the FSM `i1` input.
- `i2` output 1: conditioned channel 2; connects to the FSM `i2` input.
- `chg` output 1: one-cycle pulse in the cycle after either `i1` or `i2` changes.
- `glitch_cnt` output GC_W: saturating count of rejected transitions.

## Operation
- Reset values: all synchroniser flops 0, `i1`=0, `i2`=0, `chg`=0, `glitch_cnt`=0, both channel FSMs in STABLE with counter 0.
- Reset behaviour:
  - Assertion takes effect immediately, including mid-debounce. Any partial count is discarded.
  - After release, a raw level of 1 is treated as a new transition.
- Each channel has an independent FSM, with `s` = synchroniser output and `q` = conditioned output:
  - STABLE: if `s`==`q`, stay. If `s`!=`q`, go to CHECK and set cnt=1.
  - CHECK, `s`==`q` (bounce back): go to STABLE, cnt=0, and request a glitch increment.
  - CHECK, `s`!=`q` and cnt<DB_CYCLES-1: cnt++.
  - CHECK, `s`!=`q` and cnt==DB_CYCLES-1: `q` takes `s`, go to STABLE, cnt=0.
- `chg` is the registered value of (`i1` changed or `i2` changed) this cycle. If both channels change in the same cycle, `chg` gives a single pulse.
- `glitch_cnt`:
  - Increments by the number of channels rejecting in that cycle (0, 1 or 2).
  - Saturates at 2^GC_W-1 and never wraps; a +2 step at 2^GC_W-2 clamps to the maximum.
- Counter width inside each channel is sized to hold DB_CYCLES-1.

## Timing
- Synchroniser latency: a raw change sampled at edge k appears on `s` after edge k+SYNC_STAGES-1.
- Debounce latency: with clean raw input, `q` changes on the edge DB_CYCLES after `s` first differs. Total is SYNC_STAGES+DB_CYCLES edges; with defaults, 6 edges (120 ns at 20 ns period).
- `chg` is high exactly one cycle, one edge after the output changes.
- A raw pulse shorter than DB_CYCLES cycles at `s` never reaches `i1`/`i2` and increments `glitch_cnt` exactly once.
- All outputs are registered; there is no combinational path from `*_raw` to any output.

## Configuration
- `SM_IN_DEBOUNCE_EN` defined: full behaviour as above.
- `SM_IN_DEBOUNCE_EN` undefined:
  - Debounce FSMs are removed and `i1`/`i2` equal the synchroniser outputs.
  - Latency is SYNC_STAGES edges.
  - `glitch_cnt` is tied to 0.
  - `chg` behaves as specified.
  - `DB_CYCLES` is ignored.

## Structure
- Shared package `sm_pkg` holds:
  - the channel state encoding: DB_STABLE=1'b0, DB_CHECK=1'b1;
  - the default constants SYNC_STAGES_DEF=2, DB_CYCLES_DEF=4, GC_W_DEF=8.
- One sub-module, `sm_in_debounce`: a single channel with synchroniser, FSM and counter, outputs `q` and `rej`. It is instantiated twice.
- The top level contains `chg` generation and the `glitch_cnt` adder/saturation only.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both raw inputs at 1 -> all outputs 0 during reset. After release, `i1`=`i2`=1 at the 6th edge, with `chg` pulsing one cycle later.
- Clean step: `i1_raw` 0->1 and held -> `i1` rises after 6 edges, `chg`=1 for one cycle, `glitch_cnt` unchanged.
- Glitch: `i2_raw` high for 2 cycles, then low -> `i2` stays 0, `glitch_cnt`=1.
- Simultaneous: both raw inputs toggle in the same cycle -> `i1` and `i2` change on the same edge, a single `chg` pulse, then `glitch_cnt` 0->2 when both are glitched together.
- Saturation: with GC_W=2, apply 5 single-channel glitches -> `glitch_cnt` sequence 1,2,3,3,3.
- Mid-operation reset: assert `rst` while the channel counter is at 2 -> immediate return to reset values; after release, the full 6-edge latency applies again.
